// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer.
// Holds the per-channel FSM encoding and the default settle time.
package debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } state_t;

    // 20 ms at 50 MHz
    localparam int DEFAULT_STABLE_CYCLES = 1000000;

endpackage

// File: rtl/debounce_bit.sv
// One debounced switch channel.
// Contains a 2-flop synchronizer, a STABLE/COUNT FSM and a settle counter.
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic counting
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t          state;
    logic            meta;
    logic            sync;
    logic [CW-1:0]   cnt;

    assign counting = (state == COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            cnt   <= '0;
            state <= STABLE;
        end else begin
            meta <= raw;
            sync <= meta;
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                STABLE: begin
                    if (sync == clean) begin
                        cnt <= '0;
                    end else if (STABLE_CYCLES == 1) begin
                        clean <= sync;
                        rise  <= sync;
                        fall  <= ~sync;
                        cnt   <= '0;
                    end else begin
                        state <= COUNT;
                        cnt   <= ONE;
                    end
                end
                COUNT: begin
                    if (sync == clean) begin
                        // bounce: drop the partial count
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        clean <= sync;
                        rise  <= sync;
                        fall  <= ~sync;
                        state <= STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer with edge pulses.
// Each channel is independent; busy flags any channel mid-settle.
module switch_debounce
    import debounce_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             busy
);

    logic [WIDTH-1:0] counting;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw      (sw_raw[i]),
            .clean    (sw_clean[i]),
            .rise     (sw_rise[i]),
            .fall     (sw_fall[i]),
            .counting (counting[i])
        );
    end

    assign busy = |counting;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with WIDTH=2, STABLE_CYCLES=4.
// Stimulus queues expected outputs by cycle; a negedge monitor checks them.
module tb_switch_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sw_raw;
    logic [1:0] sw_clean;
    logic [1:0] sw_rise;
    logic [1:0] sw_fall;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise0_cnt = 0;

    typedef struct {
        int         cyc;
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       busy;
        string      name;
    } exp_t;

    exp_t q[$];

    switch_debounce #(
        .WIDTH(2),
        .STABLE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int off, input logic [1:0] c,
                        input logic [1:0] r, input logic [1:0] f,
                        input logic b, input string n);
        exp_t e;
        e.cyc   = cyc + off;
        e.clean = c;
        e.rise  = r;
        e.fall  = f;
        e.busy  = b;
        e.name  = n;
        q.push_back(e);
    endtask

    // monitor: invariants every cycle, scoreboard entries on their cycle
    logic [1:0] prev_clean = 2'b00;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (sw_rise[0]) rise0_cnt++;
        checks++;
        if ((sw_rise & sw_fall) != 2'b00) begin
            errors++;
            $display("FAIL rise_fall_overlap cyc=%0d rise=%b fall=%b",
                     cyc, sw_rise, sw_fall);
        end
        if (rst_n && prev_valid) begin
            checks++;
            if (sw_rise != ((sw_clean ^ prev_clean) & sw_clean) ||
                sw_fall != ((sw_clean ^ prev_clean) & ~sw_clean)) begin
                errors++;
                $display("FAIL pulse_vs_toggle cyc=%0d clean=%b prev=%b rise=%b fall=%b",
                         cyc, sw_clean, prev_clean, sw_rise, sw_fall);
            end
        end
        prev_clean = sw_clean;
        prev_valid = rst_n;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s missed cyc=%0d now=%0d", e.name, e.cyc, cyc);
            end else if (sw_clean !== e.clean || sw_rise !== e.rise ||
                         sw_fall !== e.fall || busy !== e.busy) begin
                errors++;
                $display("FAIL %s cyc=%0d got clean=%b rise=%b fall=%b busy=%b want clean=%b rise=%b fall=%b busy=%b",
                         e.name, cyc, sw_clean, sw_rise, sw_fall, busy,
                         e.clean, e.rise, e.fall, e.busy);
            end
        end
    end

    initial begin
        int base;
        int pat [11] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1};

        rst_n  = 1'b0;
        sw_raw = 2'b00;
        step(3);
        push(0, 2'b00, 2'b00, 2'b00, 1'b0, "reset_state");
        step(1);
        rst_n = 1'b1;
        step(3);

        // clean step on channel 0
        sw_raw = 2'b01;
        push(1, 2'b00, 2'b00, 2'b00, 1'b0, "step_c1");
        push(2, 2'b00, 2'b00, 2'b00, 1'b0, "step_c2");
        push(3, 2'b00, 2'b00, 2'b00, 1'b1, "step_busy3");
        push(4, 2'b00, 2'b00, 2'b00, 1'b1, "step_busy4");
        push(5, 2'b00, 2'b00, 2'b00, 1'b1, "step_busy5");
        push(6, 2'b01, 2'b01, 2'b00, 1'b0, "step_rise");
        push(7, 2'b01, 2'b00, 2'b00, 1'b0, "step_after");
        step(10);

        // fall back to 0 before the bounce test
        sw_raw = 2'b00;
        push(5, 2'b01, 2'b00, 2'b00, 1'b1, "fall0_pre");
        push(6, 2'b00, 2'b00, 2'b01, 1'b0, "fall0_edge");
        push(7, 2'b00, 2'b00, 2'b00, 1'b0, "fall0_after");
        step(10);

        // bounce on channel 0
        base = rise0_cnt;
        push(12, 2'b00, 2'b00, 2'b00, 1'b1, "bounce_pre");
        push(13, 2'b01, 2'b01, 2'b00, 1'b0, "bounce_rise");
        push(14, 2'b01, 2'b00, 2'b00, 1'b0, "bounce_after");
        for (int i = 0; i < 11; i++) begin
            sw_raw[0] = pat[i][0];
            step(1);
        end
        step(8);
        checks++;
        if (rise0_cnt - base != 1) begin
            errors++;
            $display("FAIL bounce_rise_count got=%0d want=1", rise0_cnt - base);
        end

        // 3-cycle glitch on channel 1
        sw_raw = 2'b11;
        push(3, 2'b01, 2'b00, 2'b00, 1'b1, "glitch_busy3");
        push(5, 2'b01, 2'b00, 2'b00, 1'b1, "glitch_busy5");
        push(6, 2'b01, 2'b00, 2'b00, 1'b0, "glitch_idle6");
        push(8, 2'b01, 2'b00, 2'b00, 1'b0, "glitch_idle8");
        step(3);
        sw_raw = 2'b01;
        step(10);

        // bring both high, then drop both together
        sw_raw = 2'b11;
        push(6, 2'b11, 2'b10, 2'b00, 1'b0, "both_hi_ch1");
        step(10);
        sw_raw = 2'b00;
        push(5, 2'b11, 2'b00, 2'b00, 1'b1, "both_fall_pre");
        push(6, 2'b00, 2'b00, 2'b11, 1'b0, "both_fall");
        push(7, 2'b00, 2'b00, 2'b00, 1'b0, "both_fall_after");
        step(10);

        // reset in the middle of a count
        sw_raw = 2'b01;
        push(4, 2'b00, 2'b00, 2'b00, 1'b1, "rstmid_busy");
        step(5);
        rst_n = 1'b0;
        push(0, 2'b00, 2'b00, 2'b00, 1'b0, "rstmid_clear");
        step(2);
        push(0, 2'b00, 2'b00, 2'b00, 1'b0, "rstmid_hold");
        rst_n = 1'b1;
        push(5, 2'b00, 2'b00, 2'b00, 1'b1, "rstmid_pre");
        push(6, 2'b01, 2'b01, 2'b00, 1'b0, "rstmid_rise");
        push(7, 2'b01, 2'b00, 2'b00, 1'b0, "rstmid_after");
        step(10);

        for (int i = 0; i < 20 && q.size() > 0; i++) step(1);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain left=%0d", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
